// File: rtl/fm_tile_loader.sv
// -----------------------------------------------------------------------------
// fm_tile_loader
//   Packs a byte-wide feature-map stream into 64-bit words and buffers whole
//   tiles in two ping-pong banks. One bank fills while the other drains into
//   the computation engine. Both sides use valid/ready handshakes.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    feature-map byte (first byte of a word lands in bits [7:0])
//   in_valid   in_data valid
//   in_ready   loader can accept a byte this cycle
//   out_fm     packed 64-bit word for the engine (0 while out_valid=0)
//   out_valid  out_fm valid
//   out_ready  consumer accepts out_fm this cycle
//   out_last   out_fm is the last word of its tile
//   tiles_done count of tiles fully drained, wraps
// -----------------------------------------------------------------------------
module fm_tile_loader #(
    parameter int TILE_WORDS = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      out_fm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] tiles_done
);

    localparam int IDX_W = (TILE_WORDS > 2) ? $clog2(TILE_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_WORDS - 1);

    logic [1:0]       full_r;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [2:0]       byte_idx_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [55:0]      asm_r;
    logic [CNT_W-1:0] tiles_done_r;
    logic [63:0]      mem_r [2][TILE_WORDS];

    logic             in_ready_s;
    logic             out_valid_s;
    logic             wr_acc_s;
    logic             word_done_s;
    logic             tile_wr_done_s;
    logic             rd_acc_s;
    logic             tile_rd_done_s;
    logic [1:0]       full_set_s;
    logic [1:0]       full_clr_s;
    logic [63:0]      out_fm_s;

    // Handshake decode; both ready/valid come only from registered bank flags.
    always_comb begin
        in_ready_s     = ~full_r[wr_bank_r];
        out_valid_s    = full_r[rd_bank_r];
        wr_acc_s       = in_valid & in_ready_s;
        word_done_s    = wr_acc_s & (byte_idx_r == 3'd7);
        tile_wr_done_s = word_done_s & (wr_idx_r == LAST_IDX);
        rd_acc_s       = out_valid_s & out_ready;
        tile_rd_done_s = rd_acc_s & (rd_idx_r == LAST_IDX);
    end

    // Flag set/clear masks; a completing write and a releasing read always
    // target different banks, so both updates can apply on one edge.
    always_comb begin
        full_set_s = 2'b00;
        full_clr_s = 2'b00;
        if (tile_wr_done_s) begin
            full_set_s = wr_bank_r ? 2'b10 : 2'b01;
        end else begin
            full_set_s = 2'b00;
        end
        if (tile_rd_done_s) begin
            full_clr_s = rd_bank_r ? 2'b10 : 2'b01;
        end else begin
            full_clr_s = 2'b00;
        end
    end

    // Combinational read of the draining bank, forced to zero when idle.
    always_comb begin
        out_fm_s = 64'd0;
        if (out_valid_s) begin
            out_fm_s = mem_r[rd_bank_r][rd_idx_r];
        end else begin
            out_fm_s = 64'd0;
        end
    end

    // Bank flags, bank pointers and word/byte indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r       <= 2'b00;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            byte_idx_r   <= 3'd0;
            wr_idx_r     <= '0;
            rd_idx_r     <= '0;
            asm_r        <= 56'd0;
            tiles_done_r <= '0;
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;
            if (wr_acc_s) begin
                // Shift in from the top: after 7 bytes byte 0 sits in [7:0]
                // and the 8th byte is taken straight from in_data.
                asm_r      <= {in_data, asm_r[55:8]};
                byte_idx_r <= byte_idx_r + 3'd1;
                if (tile_wr_done_s) begin
                    wr_idx_r  <= '0;
                    wr_bank_r <= ~wr_bank_r;
                end else if (word_done_s) begin
                    wr_idx_r <= wr_idx_r + IDX_W'(1);
                end
            end
            if (rd_acc_s) begin
                if (tile_rd_done_s) begin
                    rd_idx_r     <= '0;
                    rd_bank_r    <= ~rd_bank_r;
                    tiles_done_r <= tiles_done_r + CNT_W'(1);
                end else begin
                    rd_idx_r <= rd_idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Bank storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (word_done_s) begin
            mem_r[wr_bank_r][wr_idx_r] <= {in_data, asm_r};
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_fm     = out_fm_s;
    assign out_last   = out_valid_s & (rd_idx_r == LAST_IDX);
    assign tiles_done = tiles_done_r;

endmodule

// File: tb/tb_fm_tile_loader.sv
// -----------------------------------------------------------------------------
// tb_fm_tile_loader
//   Directed, self-checking bench for fm_tile_loader (TILE_WORDS=8). A second
//   instance with CNT_W=2 shares all inputs to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_fm_tile_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_fm;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] tiles_done;

    logic        in_ready2;
    logic [63:0] out_fm2;
    logic        out_valid2;
    logic        out_last2;
    logic [1:0]  tiles_done2;

    fm_tile_loader #(.TILE_WORDS(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_fm(out_fm), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .tiles_done(tiles_done)
    );

    fm_tile_loader #(.TILE_WORDS(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .out_fm(out_fm2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_last(out_last2), .tiles_done(tiles_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] exp_q[$];
    logic [63:0] asm_m;
    int          bcnt;
    int          out_pos;
    int          pops;
    int          stall_cnt;
    logic [63:0] cap_w0;
    logic [63:0] cap_w7;

    typedef struct {
        logic [7:0]  base;
        logic [63:0] exp_w0;
        logic [63:0] exp_w7;
        logic [15:0] exp_done;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        asm_m   = 64'd0;
        bcnt    = 0;
        out_pos = 0;
        pops    = 0;
        cap_w0  = 64'd0;
        cap_w7  = 64'd0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called in the posedge+1 phase; returns in the same phase after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int   waitc;
        logic acc;
        waitc    = 0;
        acc      = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!acc && waitc < 2000) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] target);
        int c;
        c = 0;
        while (tiles_done !== target && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("tiles_done", {48'd0, tiles_done}, {48'd0, target});
    endtask

    // Monitor: models byte packing and checks every presented word in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 64'd1, 64'd0);
                    end else begin
                        chk("out_fm", out_fm, exp_q[0]);
                        chk("out_last", {63'd0, out_last}, {63'd0, (out_pos == 7)});
                        if (out_ready) begin
                            if (out_pos == 0) cap_w0 = out_fm;
                            if (out_pos == 7) cap_w7 = out_fm;
                            void'(exp_q.pop_front());
                            out_pos = (out_pos + 1) % 8;
                            pops++;
                        end
                    end
                end else begin
                    chk("idle_out", {out_fm[62:0], out_last}, 64'd0);
                end
                if (in_valid && in_ready) begin
                    asm_m[8*bcnt +: 8] = in_data;
                    bcnt++;
                    if (bcnt == 8) begin
                        exp_q.push_back(asm_m);
                        bcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] exp_wrap[5];
        vecs[0] = '{8'h00, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938, 16'd1};
        vecs[1] = '{8'h40, 64'h4746454443424140, 64'h7F7E7D7C7B7A7978, 16'd2};
        vecs[2] = '{8'hC0, 64'hC7C6C5C4C3C2C1C0, 64'hFFFEFDFCFBFAF9F8, 16'd3};
        exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        stall_cnt = 0;

        // Reset state
        do_reset();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_fm", out_fm, 64'd0);
        chk("rst_tiles_done", {48'd0, tiles_done}, 64'd0);

        // Table-driven single tiles with out_ready high
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 63; i++) send_byte(8'(vecs[v].base + 8'(i)));
            chk("valid_before_last", {63'd0, out_valid}, 64'd0);
            send_byte(8'(vecs[v].base + 8'd63));
            chk("valid_after_last", {63'd0, out_valid}, 64'd1);
            wait_done(vecs[v].exp_done);
            chk("tbl_word0", cap_w0, vecs[v].exp_w0);
            chk("tbl_word7", cap_w7, vecs[v].exp_w7);
            chk("tbl_wrap_cnt", {62'd0, tiles_done2}, {62'd0, vecs[v].exp_done[1:0]});
        end

        // Both banks full, then drain and refill
        do_reset();
        for (int i = 0; i < 128; i++) send_byte(8'(i));
        repeat (3) @(posedge clk);
        #1;
        chk("both_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("both_full_valid", {63'd0, out_valid}, 64'd1);
        fork
            begin
                for (int i = 128; i < 192; i++) send_byte(8'(i));
            end
            begin
                out_ready = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("stalled_in_ready", {63'd0, in_ready}, 64'd0);
                    @(posedge clk);
                    #1;
                end
                chk("released_in_ready", {63'd0, in_ready}, 64'd1);
            end
        join
        wait_done(16'd3);
        chk("full_pops", 64'(pops), 64'd24);

        // out_ready toggling during drain
        do_reset();
        for (int i = 0; i < 64; i++) send_byte(8'(8'h10 + 8'(i)));
        for (int k = 0; k < 16; k++) begin
            out_ready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("toggle_pops", 64'(pops), 64'd8);
        wait_done(16'd1);

        // Async reset mid-cycle while a tile is valid and another is partial
        for (int i = 0; i < 64; i++) send_byte(8'(8'h40 + 8'(i)));
        for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + 8'(i)));
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_fm", out_fm, 64'd0);
        chk("async_rst_last", {63'd0, out_last}, 64'd0);
        chk("async_rst_done", {48'd0, tiles_done}, 64'd0);
        flush_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'(8'hA0 + 8'(i)));
        wait_done(16'd1);
        chk("post_rst_word0", cap_w0, 64'hA7A6A5A4A3A2A1A0);

        // Continuous 4-tile stream
        do_reset();
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        chk("stream_stalls", 64'(stall_cnt), 64'd0);
        wait_done(16'd4);
        chk("stream_pops", 64'(pops), 64'd32);

        // Counter wrap on the CNT_W=2 instance
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 64; i++) send_byte(8'(t * 16 + i));
            wait_done(16'(t + 1));
            chk("wrap_cnt", {62'd0, tiles_done2}, {62'd0, exp_wrap[t]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
